mmio_mailbox: RTL and testbench

MMIO_MAILBOX -- requirements
Module: mmio_mailbox

---
 rtl/mmio_mailbox_pkg.sv | 26 ++
 rtl/mmio_mailbox_sync_fifo.sv | 53 +++++
 rtl/mmio_mailbox.sv | 128 ++++++++++++
 tb/tb_mmio_mailbox.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_mailbox_pkg.sv
// Shared register map for the MMIO mailbox: word offsets, STATUS and CTRL bit positions.
package mmio_mailbox_pkg;

    localparam logic [31:0] DATA_OFS   = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;
    localparam logic [31:0] CTRL_OFS   = 32'h8;

    localparam int STATUS_CNT_LSB = 0;
    localparam int STATUS_CNT_W   = 6;
    localparam int STATUS_EMPTY   = 6;
    localparam int STATUS_FULL    = 7;
    localparam int STATUS_OVF     = 8;

    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_OVF   = 1;
    localparam int CTRL_THR_LSB   = 8;
    localparam int CTRL_THR_W     = 8;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DATA,
        SEL_STATUS,
        SEL_CTRL
    } reg_sel_e;

endpackage

// File: rtl/mmio_mailbox_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; storage is deliberately left unreset.
module sync_fifo #(
    parameter int Width = 32,
    parameter int Depth = 8,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PtrW'(1);
            if (do_pop)  rptr <= rptr + PtrW'(1);
            if (do_push && !do_pop)
                count <= count + CntW'(1);
            else if (!do_push && do_pop)
                count <= count - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mmio_mailbox.sv
// CPU-to-consumer MMIO mailbox: DATA/STATUS/CTRL window in front of a sync FIFO.
// Define MMIO_MAILBOX_IRQ_EN to add the o_IRQ output and the CTRL[15:8] threshold register.
module mmio_mailbox
    import mmio_mailbox_pkg::*;
#(
    parameter int          BusWidth = 32,
    parameter int          Depth    = 8,
    parameter logic [31:0] BaseAddr = 32'h0000_0080
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic [BusWidth-1:0] i_Address,
    input  logic [BusWidth-1:0] i_Write_Data,
    input  logic                i_Mem_Write,
    output logic [BusWidth-1:0] o_Read_Data,
    output logic [BusWidth-1:0] o_Out_Data,
    output logic                o_Out_Valid,
    input  logic                i_Out_Ready
`ifdef MMIO_MAILBOX_IRQ_EN
    ,
    output logic                o_IRQ
`endif
);

    localparam int CntW = $clog2(Depth) + 1;
    localparam logic [BusWidth-1:0] DataAddr   = BusWidth'(BaseAddr + DATA_OFS);
    localparam logic [BusWidth-1:0] StatusAddr = BusWidth'(BaseAddr + STATUS_OFS);
    localparam logic [BusWidth-1:0] CtrlAddr   = BusWidth'(BaseAddr + CTRL_OFS);

    reg_sel_e             sel;
    logic                 data_wr;
    logic                 ctrl_wr;
    logic                 pop_fire;
    logic                 flush;
    logic                 full;
    logic                 empty;
    logic [CntW-1:0]      count;
    logic [BusWidth-1:0]  head;
    logic                 overflow;

    always_comb begin
        sel = SEL_NONE;
        if (i_Address == DataAddr)        sel = SEL_DATA;
        else if (i_Address == StatusAddr) sel = SEL_STATUS;
        else if (i_Address == CtrlAddr)   sel = SEL_CTRL;
    end

    assign data_wr     = i_Mem_Write && (sel == SEL_DATA);
    assign ctrl_wr     = i_Mem_Write && (sel == SEL_CTRL);
    assign pop_fire    = o_Out_Valid && i_Out_Ready;
    assign flush       = ctrl_wr && i_Write_Data[CTRL_FLUSH];
    assign o_Out_Valid = !empty;
    assign o_Out_Data  = head;

    sync_fifo #(
        .Width (BusWidth),
        .Depth (Depth)
    ) u_fifo (
        .clk   (i_CLK),
        .rst   (i_RESET),
        .push  (data_wr),
        .pop   (pop_fire),
        .flush (flush),
        .wdata (i_Write_Data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Clearing takes precedence over a drop in the same cycle.
    always_ff @(posedge i_CLK) begin
        if (i_RESET)
            overflow <= 1'b0;
        else if (ctrl_wr && i_Write_Data[CTRL_CLR_OVF])
            overflow <= 1'b0;
        else if (data_wr && full && !pop_fire)
            overflow <= 1'b1;
    end

`ifdef MMIO_MAILBOX_IRQ_EN
    logic [CTRL_THR_W-1:0] irq_thr;
    logic [CTRL_THR_W-1:0] thr_nxt;
    logic [CntW-1:0]       cnt_nxt;
    logic                  push_acc;

    // Mirror the FIFO's next count so o_IRQ lines up with the count update.
    always_comb begin
        push_acc = data_wr && (!full || pop_fire);
        thr_nxt  = ctrl_wr ? i_Write_Data[CTRL_THR_LSB +: CTRL_THR_W] : irq_thr;
        cnt_nxt  = count;
        if (flush)
            cnt_nxt = '0;
        else if (push_acc && !pop_fire)
            cnt_nxt = count + CntW'(1);
        else if (!push_acc && pop_fire)
            cnt_nxt = count - CntW'(1);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            irq_thr <= CTRL_THR_W'(1);
            o_IRQ   <= 1'b0;
        end else begin
            irq_thr <= thr_nxt;
            o_IRQ   <= (32'(cnt_nxt) >= 32'(thr_nxt));
        end
    end
`endif

    always_comb begin
        o_Read_Data = '0;
        case (sel)
            SEL_DATA:   if (!empty) o_Read_Data = head;
            SEL_STATUS: begin
                o_Read_Data[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(count);
                o_Read_Data[STATUS_EMPTY] = empty;
                o_Read_Data[STATUS_FULL]  = full;
                o_Read_Data[STATUS_OVF]   = overflow;
            end
`ifdef MMIO_MAILBOX_IRQ_EN
            SEL_CTRL:   o_Read_Data[CTRL_THR_LSB +: CTRL_THR_W] = irq_thr;
`endif
            default:    o_Read_Data = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_mailbox.sv
// Directed bench for mmio_mailbox (Depth 8, base 0x80); IRQ checks compile when MMIO_MAILBOX_IRQ_EN is defined.
module tb_mmio_mailbox;

    localparam logic [31:0] A_DATA = 32'h80;
    localparam logic [31:0] A_STAT = 32'h84;
    localparam logic [31:0] A_CTRL = 32'h88;

    logic        i_CLK = 1'b0;
    logic        i_RESET = 1'b1;
    logic [31:0] i_Address = '0;
    logic [31:0] i_Write_Data = '0;
    logic        i_Mem_Write = 1'b0;
    logic [31:0] o_Read_Data;
    logic [31:0] o_Out_Data;
    logic        o_Out_Valid;
    logic        i_Out_Ready = 1'b0;
`ifdef MMIO_MAILBOX_IRQ_EN
    logic        o_IRQ;
`endif

    int tests = 0;
    int fails = 0;

    mmio_mailbox #(.BusWidth(32), .Depth(8), .BaseAddr(32'h80)) dut (
        .i_CLK        (i_CLK),
        .i_RESET      (i_RESET),
        .i_Address    (i_Address),
        .i_Write_Data (i_Write_Data),
        .i_Mem_Write  (i_Mem_Write),
        .o_Read_Data  (o_Read_Data),
        .o_Out_Data   (o_Out_Data),
        .o_Out_Valid  (o_Out_Valid),
        .i_Out_Ready  (i_Out_Ready)
`ifdef MMIO_MAILBOX_IRQ_EN
        ,
        .o_IRQ        (o_IRQ)
`endif
    );

    always #5 i_CLK = ~i_CLK;

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        i_Address    = a;
        i_Write_Data = d;
        i_Mem_Write  = 1'b1;
        @(posedge i_CLK);
        #1;
        i_Mem_Write  = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        i_Address = a;
        #1;
        d = o_Read_Data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        i_RESET = 1'b1;
        idle(2);
        i_RESET = 1'b0;
        tests++;
        if (o_Out_Valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %0b want 0", o_Out_Valid);
        end
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h040) begin
            fails++; $display("FAIL reset_status got %h want %h", r, 32'h040);
        end
        read_reg(A_CTRL, r);
        tests++;
`ifdef MMIO_MAILBOX_IRQ_EN
        if (r !== 32'h100) begin
            fails++; $display("FAIL reset_ctrl got %h want %h", r, 32'h100);
        end
`else
        if (r !== 32'h0) begin
            fails++; $display("FAIL reset_ctrl got %h want 0", r);
        end
`endif
    endtask

    task automatic test_single();
        logic [31:0] r;
        store(A_DATA, 32'd7);
        tests++;
        if (o_Out_Valid !== 1'b1 || o_Out_Data !== 32'd7) begin
            fails++; $display("FAIL single_head got v=%0b d=%0d want v=1 d=7", o_Out_Valid, o_Out_Data);
        end
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h001) begin
            fails++; $display("FAIL single_status got %h want %h", r, 32'h001);
        end
        read_reg(A_DATA, r);
        tests++;
        if (r !== 32'd7) begin
            fails++; $display("FAIL single_data_read got %0d want 7", r);
        end
        i_Out_Ready = 1'b1;
        idle(1);
        i_Out_Ready = 1'b0;
        read_reg(A_DATA, r);
        tests++;
        if (o_Out_Valid !== 1'b0 || r !== 32'd0) begin
            fails++; $display("FAIL single_pop got v=%0b rd=%0d want v=0 rd=0", o_Out_Valid, r);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        for (int v = 1; v <= 9; v++) store(A_DATA, 32'(v));
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h188) begin
            fails++; $display("FAIL ovf_status got %h want %h", r, 32'h188);
        end
        i_Out_Ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tests++;
            if (o_Out_Valid !== 1'b1 || o_Out_Data !== 32'(i)) begin
                fails++; $display("FAIL ovf_drain got v=%0b d=%0d want v=1 d=%0d", o_Out_Valid, o_Out_Data, i);
            end
            idle(1);
        end
        i_Out_Ready = 1'b0;
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h140) begin
            fails++; $display("FAIL ovf_sticky got %h want %h", r, 32'h140);
        end
        store(A_CTRL, 32'h2);
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h040) begin
            fails++; $display("FAIL ovf_clear got %h want %h", r, 32'h040);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] r;
        logic [31:0] exp [8];
        for (int v = 10; v <= 17; v++) store(A_DATA, 32'(v));
        i_Out_Ready = 1'b1;
        store(A_DATA, 32'd42);
        i_Out_Ready = 1'b0;
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h088) begin
            fails++; $display("FAIL fullpop_status got %h want %h", r, 32'h088);
        end
        for (int i = 0; i < 7; i++) exp[i] = 32'(11 + i);
        exp[7] = 32'd42;
        i_Out_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (o_Out_Valid !== 1'b1 || o_Out_Data !== exp[i]) begin
                fails++; $display("FAIL fullpop_drain got v=%0b d=%0d want v=1 d=%0d", o_Out_Valid, o_Out_Data, exp[i]);
            end
            idle(1);
        end
        i_Out_Ready = 1'b0;
        tests++;
        if (o_Out_Valid !== 1'b0) begin
            fails++; $display("FAIL fullpop_empty got v=%0b want 0", o_Out_Valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        for (int v = 20; v <= 28; v++) store(A_DATA, 32'(v));
        i_Out_Ready = 1'b1;
        idle(5);
        i_Out_Ready = 1'b0;
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h103 || o_Out_Data !== 32'd25) begin
            fails++; $display("FAIL flush_pre got st=%h d=%0d want st=103 d=25", r, o_Out_Data);
        end
        // A same-cycle pop must not survive the flush.
        i_Out_Ready = 1'b1;
        store(A_CTRL, 32'h3);
        i_Out_Ready = 1'b0;
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h040 || o_Out_Valid !== 1'b0) begin
            fails++; $display("FAIL flush_post got st=%h v=%0b want st=040 v=0", r, o_Out_Valid);
        end
        store(A_DATA, 32'd99);
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h001 || o_Out_Data !== 32'd99) begin
            fails++; $display("FAIL flush_reuse got st=%h d=%0d want st=001 d=99", r, o_Out_Data);
        end
        i_Out_Ready = 1'b1;
        idle(1);
        i_Out_Ready = 1'b0;
    endtask

    task automatic test_reset_push();
        logic [31:0] r;
        for (int v = 30; v <= 34; v++) store(A_DATA, 32'(v));
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h005) begin
            fails++; $display("FAIL rstpush_pre got %h want %h", r, 32'h005);
        end
        i_RESET = 1'b1;
        store(A_DATA, 32'd35);
        i_RESET = 1'b0;
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h040 || o_Out_Valid !== 1'b0) begin
            fails++; $display("FAIL rstpush_post got st=%h v=%0b want st=040 v=0", r, o_Out_Valid);
        end
        store(A_DATA, 32'd36);
        tests++;
        if (o_Out_Data !== 32'd36 || o_Out_Valid !== 1'b1) begin
            fails++; $display("FAIL rstpush_reuse got v=%0b d=%0d want v=1 d=36", o_Out_Valid, o_Out_Data);
        end
        i_Out_Ready = 1'b1;
        idle(1);
        i_Out_Ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        store(A_DATA, 32'd50);
        i_Out_Ready = 1'b1;
        store(A_DATA, 32'd51);
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h001 || o_Out_Data !== 32'd51) begin
            fails++; $display("FAIL b2b_first got st=%h d=%0d want st=001 d=51", r, o_Out_Data);
        end
        store(A_DATA, 32'd52);
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h001 || o_Out_Data !== 32'd52) begin
            fails++; $display("FAIL b2b_second got st=%h d=%0d want st=001 d=52", r, o_Out_Data);
        end
        idle(1);
        i_Out_Ready = 1'b0;
        store(32'h8C, 32'd5);
        read_reg(A_STAT, r);
        tests++;
        if (r !== 32'h040) begin
            fails++; $display("FAIL unmapped_write got %h want %h", r, 32'h040);
        end
        read_reg(32'h8C, r);
        tests++;
        if (r !== 32'h0) begin
            fails++; $display("FAIL unmapped_read got %h want 0", r);
        end
    endtask

`ifdef MMIO_MAILBOX_IRQ_EN
    task automatic test_irq();
        logic [31:0] r;
        store(A_CTRL, 32'h400);
        read_reg(A_CTRL, r);
        tests++;
        if (r !== 32'h400) begin
            fails++; $display("FAIL irq_thr_read got %h want %h", r, 32'h400);
        end
        for (int v = 0; v < 3; v++) store(A_DATA, 32'(60 + v));
        tests++;
        if (o_IRQ !== 1'b0) begin
            fails++; $display("FAIL irq_below got %0b want 0", o_IRQ);
        end
        store(A_DATA, 32'd63);
        tests++;
        if (o_IRQ !== 1'b1) begin
            fails++; $display("FAIL irq_rise got %0b want 1", o_IRQ);
        end
        i_Out_Ready = 1'b1;
        idle(1);
        i_Out_Ready = 1'b0;
        tests++;
        if (o_IRQ !== 1'b0) begin
            fails++; $display("FAIL irq_fall got %0b want 0", o_IRQ);
        end
        store(A_CTRL, 32'h401);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_flush();
        test_reset_push();
        test_back_to_back();
`ifdef MMIO_MAILBOX_IRQ_EN
        test_irq();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
